// File: rtl/dist_map_builder.sv
// Sweeps the tile grid once per start request and writes one distance/marker
// cell per tile into the back bank of a double-buffered distance RAM.
module dist_map_builder #(
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int NUM_GHOSTS = 2,
    parameter int D_W        = 8,
    parameter int TILE_W     = 4,
    parameter int WALL_CODE  = 1
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [X_W-1:0]             pacman_x,
    input  logic [Y_W-1:0]             pacman_y,
    input  logic [X_W-1:0]             target_x,
    input  logic [Y_W-1:0]             target_y,
    input  logic [NUM_GHOSTS*X_W-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  ghost_y,
    input  logic [NUM_GHOSTS*X_W-1:0]  prev_ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  prev_ghost_y,
    output logic [X_W-1:0]             map_rd_x,
    output logic [Y_W-1:0]             map_rd_y,
    input  logic [TILE_W-1:0]          map_tile,
    output logic                       wr_en,
    output logic                       wr_bank,
    output logic [X_W-1:0]             wr_x,
    output logic [Y_W-1:0]             wr_y,
    output logic [D_W-1:0]             wr_data,
    output logic                       rd_bank,
    output logic                       busy,
    output logic                       done,
    output logic                       valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EVAL  = 2'd2;

    localparam int SUM_W = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int CMP_W = (SUM_W > D_W) ? SUM_W : D_W;

    localparam logic [D_W-1:0]   CELL_WALL  = {D_W{1'b1}};
    localparam logic [D_W-1:0]   CELL_GHOST = D_W'((2**D_W) - 2);
    localparam logic [D_W-1:0]   CELL_PREV  = D_W'((2**D_W) - 3);
    localparam logic [D_W-1:0]   CELL_SAT   = D_W'((2**D_W) - 4);
    localparam logic [CMP_W-1:0] SAT_LIM    = CMP_W'((2**D_W) - 4);

    logic [1:0]                  state_reg;
    logic [X_W-1:0]              x_reg;
    logic [Y_W-1:0]              y_reg;
    logic [X_W-1:0]              ref_x_reg;
    logic [Y_W-1:0]              ref_y_reg;
    logic [NUM_GHOSTS*X_W-1:0]   snap_gx_reg;
    logic [NUM_GHOSTS*Y_W-1:0]   snap_gy_reg;
    logic [NUM_GHOSTS*X_W-1:0]   snap_pgx_reg;
    logic [NUM_GHOSTS*Y_W-1:0]   snap_pgy_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        valid_reg;
    logic                        rd_bank_reg;

    logic                        last_x;
    logic                        last_tile;
    logic [NUM_GHOSTS-1:0]       ghost_hit;
    logic [NUM_GHOSTS-1:0]       prev_hit;
    logic [X_W-1:0]              dx;
    logic [Y_W-1:0]              dy;
    logic [SUM_W-1:0]            dist_sum;
    logic                        dist_over;
    logic [D_W-1:0]              cell_value;

    assign last_x    = (x_reg == X_W'(MAP_W - 1));
    assign last_tile = last_x && (y_reg == Y_W'(MAP_H - 1));

    // Only the reference point picked by mode is kept; the other is never needed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            x_reg        <= '0;
            y_reg        <= '0;
            ref_x_reg    <= '0;
            ref_y_reg    <= '0;
            snap_gx_reg  <= '0;
            snap_gy_reg  <= '0;
            snap_pgx_reg <= '0;
            snap_pgy_reg <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            rd_bank_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        ref_x_reg    <= mode ? target_x : pacman_x;
                        ref_y_reg    <= mode ? target_y : pacman_y;
                        snap_gx_reg  <= ghost_x;
                        snap_gy_reg  <= ghost_y;
                        snap_pgx_reg <= prev_ghost_x;
                        snap_pgy_reg <= prev_ghost_y;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_reg <= ST_EVAL;
                end
                ST_EVAL: begin
                    if (last_tile) begin
                        // Park the counters at the origin so no off-grid address is ever driven.
                        x_reg       <= '0;
                        y_reg       <= '0;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        valid_reg   <= 1'b1;
                        rd_bank_reg <= ~rd_bank_reg;
                        state_reg   <= ST_IDLE;
                    end else begin
                        if (last_x) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 1'b1;
                        end else begin
                            x_reg <= x_reg + 1'b1;
                        end
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_match
        assign ghost_hit[gi] = (snap_gx_reg[gi*X_W +: X_W] == x_reg) &&
                               (snap_gy_reg[gi*Y_W +: Y_W] == y_reg);
        assign prev_hit[gi]  = (snap_pgx_reg[gi*X_W +: X_W] == x_reg) &&
                               (snap_pgy_reg[gi*Y_W +: Y_W] == y_reg);
    end

    // The sum is one bit wider than either axis so it cannot wrap before saturation.
    always_comb begin
        dx        = (ref_x_reg >= x_reg) ? (ref_x_reg - x_reg) : (x_reg - ref_x_reg);
        dy        = (ref_y_reg >= y_reg) ? (ref_y_reg - y_reg) : (y_reg - ref_y_reg);
        dist_sum  = SUM_W'(dx) + SUM_W'(dy);
        dist_over = (CMP_W'(dist_sum) > SAT_LIM);
    end

    always_comb begin
        cell_value = '0;
        if (map_tile == TILE_W'(WALL_CODE)) begin
            cell_value = CELL_WALL;
        end else if (|ghost_hit) begin
            cell_value = CELL_GHOST;
        end else if (|prev_hit) begin
            cell_value = CELL_PREV;
        end else if (dist_over) begin
            cell_value = CELL_SAT;
        end else begin
            cell_value = D_W'(dist_sum);
        end
    end

    assign map_rd_x = x_reg;
    assign map_rd_y = y_reg;
    assign wr_en    = (state_reg == ST_EVAL);
    assign wr_x     = x_reg;
    assign wr_y     = y_reg;
    assign wr_data  = wr_en ? cell_value : '0;
    assign wr_bank  = ~rd_bank_reg;
    assign rd_bank  = rd_bank_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign valid    = valid_reg;

endmodule

// File: tb/tb_dist_map_builder.sv
// Bench for dist_map_builder: three parameterisations swept together against
// a behavioural proximity-map model, directed scenarios plus random maps.
module tb_dist_map_builder;

    localparam int NI    = 3;
    localparam int W     = 40;
    localparam int H     = 30;
    localparam int TILES = W * H;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [5:0]        pac_x, tgt_x;
    logic [4:0]        pac_y, tgt_y;
    logic [23:0]       gx_vec, pgx_vec;
    logic [19:0]       gy_vec, pgy_vec;
    int                gx[4], gy[4], pgx[4], pgy[4];

    logic [NI-1:0]     wr_en_w, wr_bank_w, rd_bank_w, busy_w, done_w, valid_w;
    logic [5:0]        wr_x_w[NI], mrx_w[NI];
    logic [4:0]        wr_y_w[NI], mry_w[NI];
    logic [7:0]        wd_w[NI];
    logic [3:0]        tile_w[NI];

    logic [3:0]        tile_mem[H][W];
    int                cap[NI][2][H][W];
    int                wr_cnt[NI]   = '{default: 0};
    int                ord_next[NI] = '{default: 0};
    int                ord_err[NI]  = '{default: 0};
    int                first_wr[NI] = '{default: 0};
    int                last_wr[NI]  = '{default: 0};
    int                cyc = 0;

    int                n_checks = 0;
    int                n_fail   = 0;
    int                exp_rd_bank;

    // model snapshot taken when a sweep is requested
    int                s_mode, s_px, s_py, s_tx, s_ty;
    int                s_gx[4], s_gy[4], s_pgx[4], s_pgy[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        gx_vec = '0; gy_vec = '0; pgx_vec = '0; pgy_vec = '0;
        for (int i = 0; i < 4; i++) begin
            gx_vec[i*6 +: 6]  = 6'(gx[i]);
            gy_vec[i*5 +: 5]  = 5'(gy[i]);
            pgx_vec[i*6 +: 6] = 6'(pgx[i]);
            pgy_vec[i*5 +: 5] = 5'(pgy[i]);
        end
    end

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int DW = (gi == 1) ? 6 : 8;
        localparam int NG = (gi == 2) ? 4 : 2;
        logic [DW-1:0] wd;
        dist_map_builder #(
            .MAP_W(W), .MAP_H(H), .X_W(6), .Y_W(5), .NUM_GHOSTS(NG),
            .D_W(DW), .TILE_W(4), .WALL_CODE(1)
        ) u_dut (
            .CLOCK_50     (clk),
            .reset        (reset),
            .start        (start),
            .mode         (mode),
            .pacman_x     (pac_x),
            .pacman_y     (pac_y),
            .target_x     (tgt_x),
            .target_y     (tgt_y),
            .ghost_x      (gx_vec[NG*6-1:0]),
            .ghost_y      (gy_vec[NG*5-1:0]),
            .prev_ghost_x (pgx_vec[NG*6-1:0]),
            .prev_ghost_y (pgy_vec[NG*5-1:0]),
            .map_rd_x     (mrx_w[gi]),
            .map_rd_y     (mry_w[gi]),
            .map_tile     (tile_w[gi]),
            .wr_en        (wr_en_w[gi]),
            .wr_bank      (wr_bank_w[gi]),
            .wr_x         (wr_x_w[gi]),
            .wr_y         (wr_y_w[gi]),
            .wr_data      (wd),
            .rd_bank      (rd_bank_w[gi]),
            .busy         (busy_w[gi]),
            .done         (done_w[gi]),
            .valid        (valid_w[gi])
        );
        assign wd_w[gi] = 8'(wd);
    end

    // main map RAM with one cycle of read latency
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++)
            tile_w[i] <= (mrx_w[i] < W && mry_w[i] < H) ? tile_mem[mry_w[i]][mrx_w[i]] : 4'd0;
    end

    function automatic int raster(input logic [5:0] x, input logic [4:0] y);
        return int'(y) * W + int'(x);
    endfunction

    // distance RAM: record every write and its raster position
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                ord_next[i] <= 0;
            end else if (wr_en_w[i]) begin
                ord_err[i]  <= ord_err[i] + ((wr_x_w[i] >= W || wr_y_w[i] >= H ||
                               raster(wr_x_w[i], wr_y_w[i]) != ord_next[i]) ? 1 : 0);
                ord_next[i] <= (raster(wr_x_w[i], wr_y_w[i]) >= TILES - 1) ? 0 :
                               raster(wr_x_w[i], wr_y_w[i]) + 1;
                wr_cnt[i]   <= wr_cnt[i] + 1;
                last_wr[i]  <= cyc;
                if (wr_x_w[i] == 0 && wr_y_w[i] == 0) first_wr[i] <= cyc;
                if (wr_x_w[i] < W && wr_y_w[i] < H)
                    cap[i][wr_bank_w[i]][wr_y_w[i]][wr_x_w[i]] <= int'(wd_w[i]);
            end
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // expected cell straight from the marker priority and saturated Manhattan distance
    function automatic int exp_cell(input int inst, input int x, input int y);
        int dw  = (inst == 1) ? 6 : 8;
        int ng  = (inst == 2) ? 4 : 2;
        int top = (1 << dw) - 1;
        int d;
        if (tile_mem[y][x] == 4'd1) return top;
        for (int i = 0; i < ng; i++) if (s_gx[i] == x && s_gy[i] == y) return top - 1;
        for (int i = 0; i < ng; i++) if (s_pgx[i] == x && s_pgy[i] == y) return top - 2;
        d = s_mode ? iabs(s_tx - x) + iabs(s_ty - y) : iabs(s_px - x) + iabs(s_py - y);
        return (d > top - 3) ? top - 3 : d;
    endfunction

    task automatic take_snapshot();
        s_mode = int'(mode); s_px = int'(pac_x); s_py = int'(pac_y);
        s_tx = int'(tgt_x); s_ty = int'(tgt_y);
        for (int i = 0; i < 4; i++) begin
            s_gx[i] = gx[i]; s_gy[i] = gy[i]; s_pgx[i] = pgx[i]; s_pgy[i] = pgy[i];
        end
    endtask

    task automatic clear_map();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) tile_mem[y][x] = 4'd0;
    endtask

    task automatic set_ghost(input int i, input int x, input int y, input int px, input int py);
        gx[i] = x; gy[i] = y; pgx[i] = px; pgy[i] = py;
    endtask

    task automatic begin_sweep();
        take_snapshot();
        @(negedge clk);
        start = 1'b1;
    endtask

    // Called with the start edge coming up next; returns at the negedge that sees done.
    task automatic finish_sweep(input bit release_start, input bit perturb, input bit extra_starts);
        int t0, exp_bank;
        int base[NI];
        bit seen;
        exp_bank = 1 - exp_rd_bank;
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < NI; i++) base[i] = wr_cnt[i];
        if (release_start) start = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (cyc - t0 == 600) begin
                check_eq("mid_wr_bank", wr_bank_w[0], exp_bank);
                check_eq("mid_busy", busy_w[0], 1);
            end
            if (extra_starts && cyc - t0 == 300) start = 1'b1;
            if (extra_starts && cyc - t0 == 303) start = 1'b0;
            if (perturb && cyc - t0 == 1000) begin
                pac_x = 6'($urandom_range(0, W-1)); pac_y = 5'($urandom_range(0, H-1));
                tgt_x = 6'($urandom_range(0, W-1)); tgt_y = 5'($urandom_range(0, H-1));
                mode  = ~mode;
                for (int i = 0; i < 4; i++)
                    set_ghost(i, $urandom_range(0, W-1), $urandom_range(0, H-1),
                              $urandom_range(0, W-1), $urandom_range(0, H-1));
            end
            if (done_w[0]) seen = 1'b1;
        end
        check_eq("done_seen", seen, 1);
        if (!seen) return;
        exp_rd_bank = exp_bank;
        // done is registered on the 2*W*H-th edge after the start edge
        check_eq("done_latency", cyc - t0, 2 * TILES);
        check_eq("first_wr_latency", first_wr[0] - t0, 1);
        check_eq("last_wr_latency", last_wr[0] - t0, 2 * TILES - 1);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("done[%0d]", i), done_w[i], 1);
            check_eq($sformatf("busy_end[%0d]", i), busy_w[i], 0);
            check_eq($sformatf("rd_bank[%0d]", i), rd_bank_w[i], exp_bank);
            check_eq($sformatf("valid[%0d]", i), valid_w[i], 1);
            check_eq($sformatf("wr_count[%0d]", i), wr_cnt[i] - base[i], TILES);
            check_eq($sformatf("raster_order[%0d]", i), ord_err[i], 0);
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    check_eq($sformatf("cell[%0d](%0d,%0d)", i, x, y),
                             cap[i][exp_bank][y][x], exp_cell(i, x, y));
        end
    endtask

    function automatic int cell_of(input int inst, input int x, input int y);
        return cap[inst][exp_rd_bank][y][x];
    endfunction

    initial begin
        int base0;
        bit hit;

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        pac_x = 6'd20; pac_y = 5'd20; tgt_x = 6'd0; tgt_y = 5'd0;
        for (int i = 0; i < 4; i++) set_ghost(i, 0, 0, 0, 0);
        clear_map();
        exp_rd_bank = 0;

        // reset state
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy_w[0], 0);
        check_eq("rst_done", done_w[0], 0);
        check_eq("rst_valid", valid_w[0], 0);
        check_eq("rst_rd_bank", rd_bank_w[0], 0);
        check_eq("rst_wr_bank", wr_bank_w[0], 1);
        check_eq("rst_wr_en", wr_en_w[0], 0);
        check_eq("rst_wr_data", wd_w[0], 0);
        check_eq("rst_map_rd", {mrx_w[0], mry_w[0]}, 0);
        check_eq("rst_wr_xy", {wr_x_w[0], wr_y_w[0]}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // basic sweep, distance to pacman
        clear_map();
        tile_mem[0][0] = 4'd1; tile_mem[5][5] = 4'd1;
        mode = 1'b0; pac_x = 6'd20; pac_y = 5'd20;
        set_ghost(0, 16, 13, 16, 13); set_ghost(1, 23, 13, 23, 13);
        set_ghost(2, 35, 2, 35, 2);   set_ghost(3, 36, 2, 36, 2);
        begin_sweep();
        finish_sweep(1'b1, 1'b0, 1'b0);
        check_eq("c(15,13)", cell_of(0, 15, 13), 12);
        check_eq("c(17,13)", cell_of(0, 17, 13), 10);
        check_eq("c(22,13)", cell_of(0, 22, 13), 9);
        check_eq("c(21,14)", cell_of(0, 21, 14), 7);
        check_eq("c(16,13)", cell_of(0, 16, 13), 254);
        check_eq("c(0,0)", cell_of(0, 0, 0), 255);
        check_eq("c(5,5)", cell_of(0, 5, 5), 255);
        @(negedge clk);
        check_eq("done_one_cycle", done_w[0], 0);

        // marker priority
        clear_map();
        tile_mem[10][12] = 4'd1; tile_mem[5][5] = 4'd1;
        set_ghost(0, 11, 10, 10, 10); set_ghost(1, 5, 5, 5, 5);
        set_ghost(2, 30, 25, 30, 25); set_ghost(3, 31, 25, 31, 25);
        begin_sweep();
        finish_sweep(1'b1, 1'b0, 1'b0);
        check_eq("prev(10,10)", cell_of(0, 10, 10), 253);
        check_eq("ghost(11,10)", cell_of(0, 11, 10), 254);
        check_eq("wall(12,10)", cell_of(0, 12, 10), 255);
        check_eq("ghost_on_wall", cell_of(0, 5, 5), 255);

        // target mode, narrow cells, inputs disturbed mid-sweep
        clear_map();
        mode = 1'b1; tgt_x = 6'd0; tgt_y = 5'd0;
        for (int i = 0; i < 4; i++) set_ghost(i, 1 + i, 20, 1 + i, 20);
        begin_sweep();
        finish_sweep(1'b1, 1'b1, 1'b0);
        check_eq("sat_dw6(39,29)", cell_of(1, 39, 29), 60);
        check_eq("dw6(10,5)", cell_of(1, 10, 5), 15);
        check_eq("dw8(39,29)", cell_of(0, 39, 29), 68);

        // four ghosts
        clear_map();
        mode = 1'b0; pac_x = 6'd20; pac_y = 5'd20;
        set_ghost(0, 3, 3, 3, 3);     set_ghost(1, 7, 8, 7, 8);
        set_ghost(2, 30, 20, 30, 20); set_ghost(3, 38, 28, 12, 25);
        begin_sweep();
        finish_sweep(1'b1, 1'b0, 1'b0);
        check_eq("g4_0", cell_of(2, 3, 3), 254);
        check_eq("g4_1", cell_of(2, 7, 8), 254);
        check_eq("g4_2", cell_of(2, 30, 20), 254);
        check_eq("g4_3", cell_of(2, 38, 28), 254);
        check_eq("g4_prev3", cell_of(2, 12, 25), 253);

        // back-to-back sweeps with start held, extra starts while busy
        begin_sweep();
        finish_sweep(1'b0, 1'b0, 1'b0);
        check_eq("b2b_rd_bank1", rd_bank_w[0], 1);
        finish_sweep(1'b1, 1'b0, 1'b1);
        check_eq("b2b_rd_bank2", rd_bank_w[0], 0);
        base0 = wr_cnt[0];
        repeat (20) @(negedge clk);
        check_eq("no_third_busy", busy_w[0], 0);
        check_eq("no_third_writes", wr_cnt[0] - base0, 0);

        // asynchronous reset in the middle of a sweep
        begin_sweep();
        @(negedge clk);
        start = 1'b0;
        base0 = wr_cnt[0];
        hit = 1'b0;
        for (int n = 0; n < 1500 && !hit; n++) begin
            @(negedge clk);
            if (wr_cnt[0] - base0 >= 500) hit = 1'b1;
        end
        check_eq("reach_500_writes", hit, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", busy_w[0], 0);
        check_eq("arst_wr_en", wr_en_w[0], 0);
        check_eq("arst_valid", valid_w[0], 0);
        check_eq("arst_rd_bank", rd_bank_w[0], 0);
        exp_rd_bank = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        begin_sweep();
        finish_sweep(1'b1, 1'b0, 1'b0);

        // random maps and positions
        for (int r = 0; r < 3; r++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    int code;
                    code = $urandom_range(0, 14);
                    if (code >= 1) code++;
                    tile_mem[y][x] = ($urandom_range(0, 9) == 0) ? 4'd1 : 4'(code);
                end
            mode  = 1'($urandom_range(0, 1));
            pac_x = 6'($urandom_range(0, W-1)); pac_y = 5'($urandom_range(0, H-1));
            tgt_x = 6'($urandom_range(0, W-1)); tgt_y = 5'($urandom_range(0, H-1));
            for (int i = 0; i < 4; i++)
                set_ghost(i, $urandom_range(0, W-1), $urandom_range(0, H-1),
                          $urandom_range(0, W-1), $urandom_range(0, H-1));
            begin_sweep();
            finish_sweep(1'b1, 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
